// File: rtl/cdb_pkg.sv
// Shared definitions for the Common Data Bus arbiter: widths, producer label
// encoding and the round-robin pointer helper.
package cdb_pkg;

    localparam int LW_DEF   = 4;
    localparam int DW_DEF   = 32;
    localparam int NO_LABEL = 0;

    // Producer labels: reservation-queue entries and functional units
    localparam logic [3:0] QUE_ADD1 = 4'd1;
    localparam logic [3:0] QUE_ADD2 = 4'd2;
    localparam logic [3:0] QUE_ADD3 = 4'd3;
    localparam logic [3:0] QUE_MUL1 = 4'd4;
    localparam logic [3:0] QUE_MUL2 = 4'd5;
    localparam logic [3:0] QUE_LD1  = 4'd6;
    localparam logic [3:0] QUE_LD2  = 4'd7;
    localparam logic [3:0] FU_ADD   = 4'd8;
    localparam logic [3:0] FU_MUL   = 4'd9;
    localparam logic [3:0] FU_LD    = 4'd10;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping
// at N. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [PW-1:0] idx_s;
    logic          hit_s;

    // Scan from ptr upward, latching only the first hit
    always_comb begin
        grant       = {N{1'b0}};
        grant_idx   = {PW{1'b0}};
        grant_valid = 1'b0;
        idx_s       = {PW{1'b0}};
        hit_s       = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx_s        = PW'((int'(ptr) + k) % N);
            hit_s        = !grant_valid && req[idx_s];
            grant[idx_s] = grant[idx_s] | hit_s;
            grant_idx    = hit_s ? idx_s : grant_idx;
            grant_valid  = grant_valid | hit_s;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one-entry result slot per functional unit, one
// round-robin grant per cycle, registered broadcast of label and data.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = DW_DEF,
    parameter int LW   = LW_DEF
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 FLUSH,
    input  logic [NREQ-1:0]      reqValid,
    input  logic [NREQ*LW-1:0]   reqLabel,
    input  logic [NREQ*DW-1:0]   reqData,
    output logic [NREQ-1:0]      reqAck,
    output logic                 BCEN,
    output logic [LW-1:0]        BClabel,
    output logic [DW-1:0]        BCdata,
    output logic [NREQ-1:0]      pending,
    output logic                 labelErr
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    slot_state_e   slot_q       [NREQ];
    slot_state_e   slot_d       [NREQ];
    logic [LW-1:0] slot_label_q [NREQ];
    logic [LW-1:0] slot_label_d [NREQ];
    logic [DW-1:0] slot_data_q  [NREQ];
    logic [DW-1:0] slot_data_d  [NREQ];
    logic [PW-1:0] ptr_q, ptr_d;
    logic          bcen_q, bcen_d;
    logic [LW-1:0] bclabel_q, bclabel_d;
    logic [DW-1:0] bcdata_q, bcdata_d;
    logic          label_err_q, label_err_d;

    logic [NREQ-1:0] full_s;
    logic [NREQ-1:0] bad_label_s;
    logic [NREQ-1:0] grant_s;
    logic [NREQ-1:0] ack_s;
    logic [PW-1:0]   grant_idx_s;
    logic            grant_valid_s;

    // Slot occupancy and label-0 detection
    always_comb begin
        full_s      = {NREQ{1'b0}};
        bad_label_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            full_s[i]      = (slot_q[i] == SLOT_FULL);
            bad_label_s[i] = reqValid[i] && (reqLabel[i*LW +: LW] == LW'(NO_LABEL));
        end
    end

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr (
        .req         (full_s),
        .ptr         (ptr_q),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // A full slot can take a new result only in the cycle it is being granted
    always_comb begin
        ack_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            ack_s[i] = reqValid[i] && !bad_label_s[i] && !FLUSH && !RST
                       && (!full_s[i] || grant_s[i]);
        end
    end

    // Next state for slots, pointer and broadcast register
    always_comb begin
        slot_d       = slot_q;
        slot_label_d = slot_label_q;
        slot_data_d  = slot_data_q;
        ptr_d        = ptr_q;
        bcen_d       = 1'b0;
        bclabel_d    = bclabel_q;
        bcdata_d     = bcdata_q;
        label_err_d  = label_err_q | (|bad_label_s);
        if (FLUSH) begin
            for (int i = 0; i < NREQ; i++) begin
                slot_d[i] = SLOT_EMPTY;
            end
        end else begin
            if (grant_valid_s) begin
                bcen_d              = 1'b1;
                bclabel_d           = slot_label_q[grant_idx_s];
                bcdata_d            = slot_data_q[grant_idx_s];
                slot_d[grant_idx_s] = SLOT_EMPTY;
                ptr_d               = PW'(rr_next(int'(grant_idx_s), NREQ));
            end else begin
                bcen_d = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                slot_d[i]       = ack_s[i] ? SLOT_FULL : slot_d[i];
                slot_label_d[i] = ack_s[i] ? reqLabel[i*LW +: LW] : slot_label_d[i];
                slot_data_d[i]  = ack_s[i] ? reqData[i*DW +: DW] : slot_data_d[i];
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (RST) begin
            for (int i = 0; i < NREQ; i++) begin
                slot_q[i]       <= SLOT_EMPTY;
                slot_label_q[i] <= {LW{1'b0}};
                slot_data_q[i]  <= {DW{1'b0}};
            end
            ptr_q       <= {PW{1'b0}};
            bcen_q      <= 1'b0;
            bclabel_q   <= {LW{1'b0}};
            bcdata_q    <= {DW{1'b0}};
            label_err_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            slot_label_q <= slot_label_d;
            slot_data_q  <= slot_data_d;
            ptr_q        <= ptr_d;
            bcen_q       <= bcen_d;
            bclabel_q    <= bclabel_d;
            bcdata_q     <= bcdata_d;
            label_err_q  <= label_err_d;
        end
    end

    assign reqAck   = ack_s;
    assign BCEN     = bcen_q;
    assign BClabel  = bclabel_q;
    assign BCdata   = bcdata_q;
    assign pending  = full_s;
    assign labelErr = label_err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, a full-load round-robin
// sequence, and randomized traffic against a behavioural slot/queue model.
module tb_cdb_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int LW   = 4;

    logic                   clk = 1'b0;
    logic                   RST = 1'b0;
    logic                   FLUSH = 1'b0;
    logic [NREQ-1:0]        reqValid = '0;
    logic [NREQ-1:0][LW-1:0] reqLabel = '0;
    logic [NREQ-1:0][DW-1:0] reqData = '0;
    logic [NREQ-1:0]        reqAck;
    logic                   BCEN;
    logic [LW-1:0]          BClabel;
    logic [DW-1:0]          BCdata;
    logic [NREQ-1:0]        pending;
    logic                   labelErr;

    cdb_arbiter #(.NREQ(NREQ), .DW(DW), .LW(LW)) dut (
        .clk      (clk),
        .RST      (RST),
        .FLUSH    (FLUSH),
        .reqValid (reqValid),
        .reqLabel (reqLabel),
        .reqData  (reqData),
        .reqAck   (reqAck),
        .BCEN     (BCEN),
        .BClabel  (BClabel),
        .BCdata   (BCdata),
        .pending  (pending),
        .labelErr (labelErr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: one buffered result per unit plus rotating priority
    bit [NREQ-1:0] m_full = '0;
    logic [LW-1:0] m_lab [NREQ];
    logic [DW-1:0] m_dat [NREQ];
    int            m_ptr = 0;
    logic          m_bcen = 1'b0;
    logic [LW-1:0] m_bclab = '0;
    logic [DW-1:0] m_bcdat = '0;
    logic          m_err = 1'b0;
    logic [NREQ-1:0] m_ack;
    logic [NREQ-1:0] ack_seen;

    typedef struct {
        logic                    rst;
        logic                    flush;
        logic [NREQ-1:0]         valid;
        logic [NREQ-1:0][LW-1:0] lab;
        logic [NREQ-1:0][DW-1:0] dat;
        logic [NREQ-1:0]         e_ack;
        logic                    e_bcen;
        logic [LW-1:0]           e_lab;
        logic [DW-1:0]           e_dat;
        logic [NREQ-1:0]         e_pend;
        logic                    e_err;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_cycle(input logic rst, input logic fl, input logic [NREQ-1:0] v,
                             input logic [NREQ-1:0][LW-1:0] lab,
                             input logic [NREQ-1:0][DW-1:0] dat);
        int gi;
        RST = rst; FLUSH = fl; reqValid = v; reqLabel = lab; reqData = dat;
        @(negedge clk);
        ack_seen = reqAck;
        gi = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (gi < 0 && m_full[idx]) gi = idx;
        end
        for (int i = 0; i < NREQ; i++)
            m_ack[i] = v[i] && (lab[i] != 0) && !fl && !rst && (!m_full[i] || gi == i);
        @(posedge clk);
        if (rst) begin
            m_full = '0; m_ptr = 0; m_bcen = 1'b0; m_bclab = '0; m_bcdat = '0; m_err = 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (v[i] && lab[i] == 0) m_err = 1'b1;
            if (fl) begin
                m_full = '0;
                m_bcen = 1'b0;
            end else begin
                if (gi >= 0) begin
                    m_bcen = 1'b1; m_bclab = m_lab[gi]; m_bcdat = m_dat[gi];
                    m_full[gi] = 1'b0;
                    m_ptr = (gi + 1) % NREQ;
                end else begin
                    m_bcen = 1'b0;
                end
                for (int i = 0; i < NREQ; i++)
                    if (m_ack[i]) begin
                        m_full[i] = 1'b1; m_lab[i] = lab[i]; m_dat[i] = dat[i];
                    end
            end
        end
        #1;
    endtask

    task automatic check_model();
        chk("ack", 32'(ack_seen), 32'(m_ack));
        chk("bcen", 32'(BCEN), 32'(m_bcen));
        chk("bclabel", 32'(BClabel), 32'(m_bclab));
        chk("bcdata", BCdata, m_bcdat);
        chk("pending", 32'(pending), 32'(m_full));
        chk("labelerr", 32'(labelErr), 32'(m_err));
    endtask

    initial begin
        int exp_unit, acks, pulses;
        logic [NREQ-1:0]         rv;
        logic [NREQ-1:0][LW-1:0] rl;
        logic [NREQ-1:0][DW-1:0] rd;

        for (int i = 0; i < NREQ; i++) begin m_lab[i] = '0; m_dat[i] = '0; end

        //            rst   fl    valid    labels    data                                               ack      bcen  lab   data           pend     err
        tbl[0]  = '{1'b1, 1'b0, 4'b0000, 16'h0000, 128'h0,                                            4'b0000, 1'b0, 4'h0, 32'h0,        4'b0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 4'b0010, 16'h0050, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0},               4'b0010, 1'b0, 4'h0, 32'h0,        4'b0010, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 4'b0000, 16'h0000, 128'h0,                                            4'b0000, 1'b1, 4'h5, 32'hDEADBEEF, 4'b0000, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 4'b0000, 16'h0000, 128'h0,                                            4'b0000, 1'b0, 4'h5, 32'hDEADBEEF, 4'b0000, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 4'b0001, 16'h0000, {32'h0, 32'h0, 32'h0, 32'h12345678},               4'b0000, 1'b0, 4'h5, 32'hDEADBEEF, 4'b0000, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 4'b0000, 16'h0000, 128'h0,                                            4'b0000, 1'b0, 4'h5, 32'hDEADBEEF, 4'b0000, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 4'b0100, 16'h0600, {32'h0, 32'h66, 32'h0, 32'h0},                     4'b0100, 1'b0, 4'h5, 32'hDEADBEEF, 4'b0100, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 4'b0100, 16'h0700, {32'h0, 32'h77, 32'h0, 32'h0},                     4'b0100, 1'b1, 4'h6, 32'h66,       4'b0100, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 4'b0000, 16'h0000, 128'h0,                                            4'b0000, 1'b1, 4'h7, 32'h77,       4'b0000, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 4'b0000, 16'h0000, 128'h0,                                            4'b0000, 1'b0, 4'h7, 32'h77,       4'b0000, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 4'b1011, 16'hA098, {32'hAA, 32'h0, 32'h99, 32'h88},                   4'b1011, 1'b0, 4'h7, 32'h77,       4'b1011, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 4'b1011, 16'hB0CD, {32'hBB, 32'h0, 32'hCC, 32'hDD},                   4'b0000, 1'b0, 4'h7, 32'h77,       4'b0000, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 4'b0000, 16'h0000, 128'h0,                                            4'b0000, 1'b0, 4'h7, 32'h77,       4'b0000, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 4'b1111, 16'h4321, {32'h44, 32'h33, 32'h22, 32'h11},                  4'b1111, 1'b0, 4'h7, 32'h77,       4'b1111, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 4'b1111, 16'h4321, {32'h44, 32'h33, 32'h22, 32'h11},                  4'b1000, 1'b1, 4'h4, 32'h44,       4'b1111, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 4'b1111, 16'h4321, {32'h44, 32'h33, 32'h22, 32'h11},                  4'b0000, 1'b0, 4'h0, 32'h0,        4'b0000, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 4'b0000, 16'h0000, 128'h0,                                            4'b0000, 1'b0, 4'h0, 32'h0,        4'b0000, 1'b0};

        for (int n = 0; n < 17; n++) begin
            run_cycle(tbl[n].rst, tbl[n].flush, tbl[n].valid, tbl[n].lab, tbl[n].dat);
            chk($sformatf("tbl%0d_ack", n), 32'(ack_seen), 32'(tbl[n].e_ack));
            chk($sformatf("tbl%0d_bcen", n), 32'(BCEN), 32'(tbl[n].e_bcen));
            chk($sformatf("tbl%0d_bclabel", n), 32'(BClabel), 32'(tbl[n].e_lab));
            chk($sformatf("tbl%0d_bcdata", n), BCdata, tbl[n].e_dat);
            chk($sformatf("tbl%0d_pending", n), 32'(pending), 32'(tbl[n].e_pend));
            chk($sformatf("tbl%0d_labelerr", n), 32'(labelErr), 32'(tbl[n].e_err));
        end

        // Full load: every unit offers every cycle; the bus must rotate 0,1,2,3,...
        run_cycle(1'b1, 1'b0, '0, '0, '0);
        exp_unit = 0; acks = 0; pulses = 0;
        rl = {4'd4, 4'd3, 4'd2, 4'd1};
        for (int c = 0; c < 14; c++) begin
            for (int i = 0; i < NREQ; i++) rd[i] = $urandom;
            run_cycle(1'b0, 1'b0, 4'b1111, rl, rd);
            check_model();
            acks += $countones(ack_seen);
            if (BCEN) begin
                pulses++;
                chk("rr_order", 32'(BClabel), 32'(exp_unit + 1));
                exp_unit = (exp_unit + 1) % NREQ;
            end
        end
        for (int c = 0; c < 6; c++) begin
            run_cycle(1'b0, 1'b0, '0, '0, '0);
            check_model();
            pulses += int'(BCEN);
        end
        chk("pulses_per_ack", 32'(pulses), 32'(acks));

        // Randomized traffic against the model
        run_cycle(1'b1, 1'b0, '0, '0, '0);
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                rv[i] = ($urandom_range(0, 2) != 0);
                rl[i] = LW'($urandom_range(0, 15));
                rd[i] = $urandom;
            end
            run_cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0), rv, rl, rd);
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
